seq_pattern_tx: RTL and testbench
=================================

// Module: seq_pattern_tx
// PURPOSE
//   Serial pattern transmitter: the send side of the serial bit-sequence detector.
//   Accepts a parallel pattern and a repeat count via a valid/ready handshake.
//   Shifts the pattern out MSB-first, one bit per clk, repeating it with idle gaps.
//   dout drives the detector's serial data input (din) directly. Used for loopback test and stimulus.
// PARAMETERS
//   WIDTH    4        pattern length in bits (>=2)
//   REP_W    4        width of repeat-count input
//   GAP      1        idle cycles inserted between repetitions (0 = back-to-back)
// PORTS
//   clk          in   1      rising-edge clock
//   reset_n      in   1      synchronous, active-low reset
//   start_valid  in   1      request to send; held until accepted
//   start_ready  out  1      high only in IDLE; accept = start_valid & start_ready at an edge
//   pattern      in   WIDTH  pattern, sampled only at accept (e.g. 4'b1011)
//   reps         in   REP_W  repetition count, sampled only at accept
//   dout         out  1      serial data (0 when not sending)
//   dout_valid   out  1      high while dout carries a pattern bit
//   busy         out  1      high in every state except IDLE
//   done         out  1      one-cycle pulse after the final bit
// BEHAVIOUR
//   - Interface fixed: one clock, clk; reset is synchronous and active-low (reset_n).
//   - Reset: reset_n low at an edge -> state IDLE. Outputs after that edge:
//     dout=0, dout_valid=0, busy=0, done=0, start_ready=1. Counters and shift register cleared.
//   - Reset mid-frame aborts the frame immediately. No done pulse is generated.
//   - All outputs are registered or decoded from state only; none depends combinationally on inputs.
//   - FSM states: IDLE, SHIFT, GAP, DONE.
//     IDLE  -> SHIFT on accept when reps != 0. Loads shreg=pattern, rep_left=reps, bit_cnt=0.
//     IDLE  -> DONE on accept when reps == 0. No bits are sent.
//     SHIFT: dout=shreg[WIDTH-1], dout_valid=1. Each cycle, shreg shifts left and bit_cnt increments.
//       On the last bit (bit_cnt == WIDTH-1):
//         rep_left == 1           -> DONE
//         rep_left > 1 and GAP>0  -> GAP
//         rep_left > 1 and GAP==0 -> SHIFT, reload shreg from captured pattern copy
//       rep_left decrements at the end of each repetition.
//     GAP: dout=0, dout_valid=0 for exactly GAP cycles, then SHIFT with shreg reloaded.
//     DONE: done=1 for one cycle, busy=1, start_ready=0. Then -> IDLE.
//   - Latency: the first bit appears on dout in the cycle after the accept edge.
//     A frame occupies reps*WIDTH + (reps-1)*GAP cycles, then 1 DONE cycle.
//     The earliest next accept is on the edge ending the first IDLE cycle after DONE.
//   - start_valid while busy is ignored (not queued).
//     Changes to pattern/reps after accept have no effect on the current frame.
//   - Counter widths: bit_cnt is $clog2(WIDTH) bits; gap_cnt is $clog2(GAP+1) bits.
//     No wrap-around is permitted; each counter clears on every reload.
//   - reps = max (2^REP_W-1) must be sent in full, with no counter overflow.
// STRUCTURE
//   - seq_pattern_pkg: state encoding constants (IDLE/SHIFT/GAP/DONE, 2 bits) and DEFAULT_PATTERN=4'b1011.
//   - Single module, no sub-module. Contents:
//     state register, next-state logic, WIDTH shift register plus a captured pattern copy, three counters.
// TESTING
//   1 pattern=1011, reps=1 -> dout 1,0,1,1 with dout_valid=1 on cycles 1-4 after accept.
//     done=1 on cycle 5; start_ready=1 again on cycle 6.
//   2 pattern=1011, reps=3, GAP=1 -> 1011 0 1011 0 1011 (valid low on the gap bits).
//     Exactly 14 busy cycles before done.
//   3 Loopback: dout -> detector din, reps=3, GAP=1 -> exactly 3 detector out pulses,
//     each coincident with the 4th bit of a repetition.
//   4 reps=0 -> no dout_valid; done pulse the cycle after accept.
//     start_valid held during the whole frame -> a second accept happens only from IDLE.
//   5 reset_n low at the 3rd bit of a reps=2 frame -> next cycle all outputs 0, start_ready=1, no done.
//     A new frame then sends correctly.
//   6 GAP=0, reps=2, pattern=1011 -> 10111011 contiguous, dout_valid high for 8 cycles.
//     Pattern input changed mid-frame -> no effect on the output.

Source files
------------

// File: rtl/seq_pattern_pkg.sv
// Shared constants for the serial pattern transmitter: FSM encoding and default pattern.
// The 2-bit state encoding is kept stable so external monitors can decode it.
package seq_pattern_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

    // Counter width helper that never returns a zero-width vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts {pattern, reps} on a valid/ready handshake and
// shifts the pattern out MSB-first reps times, with GAP idle cycles between repetitions.
import seq_pattern_pkg::*;

module seq_pattern_tx #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    // Handshake: a request is accepted at a rising edge where start_valid and
    // start_ready are both high; start_ready is high only in IDLE and a request
    // seen while busy is simply ignored.
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [REP_W-1:0] reps,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_CW = cnt_width(WIDTH);
    // GAP == 0 would give a zero-width counter; one bit is kept and never used then.
    localparam int GAP_CW = cnt_width(GAP + 1);

    localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(WIDTH - 1);
    localparam logic [GAP_CW-1:0] LAST_GAP = (GAP > 0) ? GAP_CW'(GAP - 1) : '0;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WIDTH-1:0]  shreg;
    logic [WIDTH-1:0]  pat_copy;
    logic [REP_W-1:0]  rep_left;
    logic [BIT_CW-1:0] bit_cnt;
    logic [GAP_CW-1:0] gap_cnt;

    logic accept;
    logic last_bit;
    logic last_gap;
    logic last_rep;

    assign accept   = start_valid && (state == ST_IDLE);
    assign last_bit = (bit_cnt == LAST_BIT);
    assign last_gap = (gap_cnt == LAST_GAP);
    assign last_rep = (rep_left == REP_W'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (reps == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    if (last_rep) begin
                        state_nxt = ST_DONE;
                    end else if (GAP > 0) begin
                        state_nxt = ST_GAP;
                    end else begin
                        state_nxt = ST_SHIFT;
                    end
                end
            end
            ST_GAP: begin
                if (last_gap) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            pat_copy <= '0;
            rep_left <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shreg    <= pattern;
                        pat_copy <= pattern;
                        rep_left <= reps;
                        bit_cnt  <= '0;
                        gap_cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (last_bit) begin
                        rep_left <= rep_left - REP_W'(1);
                        bit_cnt  <= '0;
                        gap_cnt  <= '0;
                        // Back-to-back repetition reloads here; otherwise GAP reloads later.
                        if (state_nxt == ST_SHIFT) begin
                            shreg <= pat_copy;
                        end else begin
                            shreg <= {shreg[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        shreg   <= {shreg[WIDTH-2:0], 1'b0};
                        bit_cnt <= bit_cnt + BIT_CW'(1);
                    end
                end
                ST_GAP: begin
                    if (last_gap) begin
                        shreg   <= pat_copy;
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode state and the shift register only, never the inputs.
    assign dout        = (state == ST_SHIFT) ? shreg[WIDTH-1] : 1'b0;
    assign dout_valid  = (state == ST_SHIFT);
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign start_ready = (state == ST_IDLE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a GAP=1 and a GAP=0 instance, table-driven frames,
// hand-written corner sequences and random frames against a cycle-list model.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sv1 = 1'b0;
    logic       sv0 = 1'b0;
    logic [3:0] pattern = 4'b0000;
    logic [3:0] reps = 4'd0;

    logic dout1, dv1, busy1, done1, rdy1;
    logic dout0, dv0, busy0, done0, rdy0;

    always #5 clk = ~clk;

    seq_pattern_tx #(.WIDTH(4), .REP_W(4), .GAP(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start_valid(sv1), .start_ready(rdy1),
        .pattern(pattern), .reps(reps), .dout(dout1), .dout_valid(dv1),
        .busy(busy1), .done(done1)
    );

    seq_pattern_tx #(.WIDTH(4), .REP_W(4), .GAP(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .start_valid(sv0), .start_ready(rdy0),
        .pattern(pattern), .reps(reps), .dout(dout0), .dout_valid(dv0),
        .busy(busy0), .done(done0)
    );

    // Observed vector: {dout, dout_valid, busy, done, start_ready}
    logic [4:0] out1, out0, cur;
    bit         cur_sel = 1'b1;
    assign out1 = {dout1, dv1, busy1, done1, rdy1};
    assign out0 = {dout0, dv0, busy0, done0, rdy0};
    assign cur  = cur_sel ? out1 : out0;

    localparam logic [4:0] V_IDLE = 5'b00001;

    int n_checks = 0;
    int n_pass   = 0;
    logic [4:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected per-cycle outputs from accept+1 through the done cycle.
    task automatic build_model(input logic [3:0] p, input int r, input int gap);
        exp_q.delete();
        for (int k = 0; k < r; k++) begin
            for (int i = 3; i >= 0; i--) exp_q.push_back({p[i], 1'b1, 1'b1, 1'b0, 1'b0});
            if (k < r - 1)
                for (int g = 0; g < gap; g++) exp_q.push_back(5'b00100);
        end
        exp_q.push_back(5'b00110);
    endtask

    task automatic set_sv(input bit sel, input logic v);
        if (sel) sv1 = v;
        else sv0 = v;
    endtask

    task automatic run_frame(input string name, input bit sel, input logic [3:0] p,
                             input logic [3:0] r, input int exp_busy, input int exp_valid,
                             input int exp_match);
        int t, n_busy, n_valid, vidx, m_total, m_4th;
        logic [3:0] win;
        logic [4:0] e;
        cur_sel = sel;
        build_model(p, int'(r), sel ? 1 : 0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        pattern = p;
        reps = r;
        set_sv(sel, 1'b1);
        t = 0;
        while (!cur[0] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            check({name, " ready_timeout"}, 32'd0, 32'd1);
            set_sv(sel, 1'b0);
            return;
        end
        @(negedge clk);
        set_sv(sel, 1'b0);
        pattern = 4'($urandom);
        reps = 4'($urandom);
        n_busy = 0; n_valid = 0; vidx = 0; m_total = 0; m_4th = 0; win = 4'b0000;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s cyc%0d", name, n_busy), {27'd0, cur}, {27'd0, e});
            win = {win[2:0], cur[4]};
            if (cur[3]) vidx++;
            if (win == p) begin
                m_total++;
                if (cur[3] && ((vidx - 1) % 4 == 3)) m_4th++;
            end
            if (cur[2] && !cur[1]) n_busy++;
            if (cur[3]) n_valid++;
            @(negedge clk);
        end
        check({name, " idle_after"}, {27'd0, cur}, {27'd0, V_IDLE});
        if (exp_busy >= 0) check({name, " busy_cycles"}, n_busy, exp_busy);
        if (exp_valid >= 0) check({name, " valid_cycles"}, n_valid, exp_valid);
        if (exp_match >= 0) begin
            check({name, " det_pulses"}, m_total, exp_match);
            check({name, " det_on_4th_bit"}, m_4th, exp_match);
        end
    endtask

    typedef struct {
        logic [3:0] pat;
        logic [3:0] reps;
        bit         sel;
        int         exp_busy;
        int         exp_valid;
        int         exp_match;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{4'b1011, 4'd1,  1'b1, 4,  4,  1};
        vecs[1] = '{4'b1011, 4'd3,  1'b1, 14, 12, 3};
        vecs[2] = '{4'b1011, 4'd0,  1'b1, 0,  0,  0};
        vecs[3] = '{4'b1011, 4'd2,  1'b0, 8,  8,  2};
        vecs[4] = '{4'b0110, 4'd15, 1'b1, 74, 60, -1};
        vecs[5] = '{4'b1111, 4'd15, 1'b0, 60, 60, -1};
        vecs[6] = '{4'b0001, 4'd2,  1'b1, 9,  8,  -1};
        vecs[7] = '{4'b1000, 4'd5,  1'b0, 20, 20, -1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset dut1", {27'd0, out1}, {27'd0, V_IDLE});
        check("reset dut0", {27'd0, out0}, {27'd0, V_IDLE});
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].sel, vecs[i].pat, vecs[i].reps,
                      vecs[i].exp_busy, vecs[i].exp_valid, vecs[i].exp_match);

        // reps=0 with start_valid held: done next cycle, re-accept only from IDLE.
        cur_sel = 1'b1;
        @(negedge clk);
        pattern = 4'b1011; reps = 4'd0; sv1 = 1'b1;
        @(negedge clk);
        check("hold done1", {27'd0, out1}, {27'd0, 5'b00110});
        @(negedge clk);
        check("hold idle", {27'd0, out1}, {27'd0, V_IDLE});
        @(negedge clk);
        check("hold done2", {27'd0, out1}, {27'd0, 5'b00110});
        sv1 = 1'b0;
        @(negedge clk);
        check("hold idle2", {27'd0, out1}, {27'd0, V_IDLE});

        // Reset on the 3rd bit of a reps=2 frame.
        pattern = 4'b1011; reps = 4'd2; sv1 = 1'b1;
        @(negedge clk);
        sv1 = 1'b0;
        check("rst bit1", {27'd0, out1}, {27'd0, 5'b11100});
        @(negedge clk);
        check("rst bit2", {27'd0, out1}, {27'd0, 5'b01100});
        @(negedge clk);
        check("rst bit3", {27'd0, out1}, {27'd0, 5'b11100});
        reset_n = 1'b0;
        @(negedge clk);
        check("rst applied", {27'd0, out1}, {27'd0, V_IDLE});
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("rst no_done%0d", i), {27'd0, out1}, {27'd0, V_IDLE});
        end
        run_frame("after_rst", 1'b1, 4'b1011, 4'd2, 9, 8, 2);

        for (int i = 0; i < 20; i++)
            run_frame($sformatf("rnd%0d", i), 1'($urandom), 4'($urandom),
                      4'($urandom_range(0, 15)), -1, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
